// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
//   INSTR_BYTES  : bytes per instruction word; the fetch PC advances by this.
//   RESET_VECTOR : default fetch PC loaded on reset.
//   ptr_bits()   : width of a queue pointer that carries one wrap bit.
package fetch_unit_pkg;

  localparam int          INSTR_BYTES  = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // One extra bit above the index so full and empty are distinguishable.
  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: DEPTH slots holding {pc, instruction word}.
// A slot is reserved (PC written) when a memory request is accepted, filled
// (data written) when its response returns, and visible at the head only
// once filled. Three pointers walk the ring in order head <= fill <= alloc.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              frees every slot (redirect); overrides all updates
//   alloc, alloc_pc    reserve the next slot with this PC
//   fill, fill_data    write data into the oldest unfilled slot
//   pop                consume the head slot
//   full               all DEPTH slots reserved
//   unfilled           reserved slots still waiting for their response
//   head_valid/data/pc head slot contents (data/pc read as 0 when empty)
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc,
  input  logic [XLEN-1:0]      alloc_pc,
  input  logic                 fill,
  input  logic [XLEN-1:0]      fill_data,
  input  logic                 pop,
  output logic                 full,
  output logic [$clog2(DEPTH):0] unfilled,
  output logic                 head_valid,
  output logic [XLEN-1:0]      head_data,
  output logic [XLEN-1:0]      head_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_bits(DEPTH);

  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   reserved;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic            do_alloc;
  logic            do_fill;
  logic            do_pop;

  assign reserved   = alloc_ptr - head_ptr;
  assign full       = (reserved == PW'(DEPTH));
  assign unfilled   = alloc_ptr - fill_ptr;
  assign head_valid = (head_ptr != fill_ptr);

  // Guard each pointer move so a misbehaving neighbour cannot break ordering.
  assign do_alloc = alloc && !full;
  assign do_fill  = fill && (unfilled != '0);
  assign do_pop   = pop && head_valid;

  // Gate the read data so decode sees zeros whenever nothing is valid.
  assign head_data = head_valid ? data_mem[head_ptr[AW-1:0]] : '0;
  assign head_pc   = head_valid ? pc_mem[head_ptr[AW-1:0]]   : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
    end else begin
      if (do_alloc) alloc_ptr <= alloc_ptr + 1'b1;
      if (do_fill)  fill_ptr  <= fill_ptr + 1'b1;
      if (do_pop)   head_ptr  <= head_ptr + 1'b1;
    end
  end

  // Slot storage carries no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (do_alloc) pc_mem[alloc_ptr[AW-1:0]]  <= alloc_pc;
    if (do_fill)  data_mem[fill_ptr[AW-1:0]] <= fill_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end.
// Holds the fetch PC, issues word requests to a variable-latency instruction
// memory, buffers returned words with their PCs and hands them to decode.
// A redirect flushes the queue and arranges for every response still owed
// by memory to be discarded.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_req_valid/ready/addr      request channel (word-aligned byte address)
//   mem_rsp_valid/data            in-order response channel
//   redirect_valid, redirect_pc   flush and restart fetch at redirect_pc
//   halt                          stop issuing requests, keep draining
//   inst_valid/ready/data/pc      instruction channel to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int PW = ptr_bits(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   drop_cnt;
  logic [PW-1:0]   q_unfilled;
  logic            q_full;
  logic            req_fire;
  logic            rsp_drop;
  logic            q_alloc;
  logic            q_fill;
  logic            pop;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign mem_req_valid = !rst && !halt && !q_full;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses owed to pre-redirect requests are swallowed here.
  assign rsp_drop = mem_rsp_valid && (drop_cnt != '0);

  // Redirect wins over any same-cycle reservation or fill.
  assign q_alloc = req_fire && !redirect_valid;
  assign q_fill  = mem_rsp_valid && !rsp_drop && !redirect_valid;
  assign pop     = inst_valid && inst_ready;

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .alloc      (q_alloc),
    .alloc_pc   (fetch_pc),
    .fill       (q_fill),
    .fill_data  (mem_rsp_data),
    .pop        (pop),
    .full       (q_full),
    .unfilled   (q_unfilled),
    .head_valid (inst_valid),
    .head_data  (inst_data),
    .head_pc    (inst_pc)
  );

  // On redirect, everything memory still owes us becomes a drop: requests
  // already dropped, reserved-but-unfilled slots, plus a request accepted
  // this cycle, minus a response arriving this cycle (it is discarded too).
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt <= drop_cnt + q_unfilled + PW'(req_fire) - PW'(mem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the next-generation core. Replaces the single-cycle PC register, PC+4 adder and combinational instruction-memory read with a decoupled fetcher: it holds the fetch PC, issues word requests to a variable-latency instruction memory over a valid/ready request channel, buffers returned words with their PCs in a DEPTH-entry queue, and hands them to decode over a valid/ready channel. Branch, JAL and JALR resolution drive a redirect port that flushes all stale work.

## Interface
- XLEN, 32: PC and instruction width.
- DEPTH, 4: queue entries, power of two, ≥2; also the cap on in-flight plus buffered words.
- RESET_PC, 0: fetch PC loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  byte address, bits [1:0] always 0.
- mem_rsp_valid  in  1  response word valid; responses return in request order, ≥1 cycle after acceptance.
- mem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0).
- halt  in  1  stop issuing new requests (end-of-program).
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst_data  out  XLEN  instruction word.
- inst_pc  out  XLEN  PC of inst_data.

## Operation
- State: fetch_pc; queue with alloc, fill and head pointers (log2(DEPTH)+1 bits, wrap on overflow of the low bits); drop counter (log2(DEPTH)+1 bits).
- Slot reserved at request acceptance (PC written then); data written at response; slot becomes visible at head only when filled.
- mem_req_valid = !rst && !halt && (reserved slots < DEPTH). mem_req_addr = fetch_pc. On mem_req_valid && mem_req_ready: reserve slot, fetch_pc += 4 (mod 2^XLEN).
- Response with drop counter > 0: discarded, drop counter decrements; otherwise fills the oldest unfilled slot.
- inst_valid = head slot filled. inst_valid && inst_ready pops head.
- Redirect: fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}; all queue slots freed; drop counter <= requests accepted but unanswered, counting a request accepted in the redirect cycle and excluding a response arriving in it (that response is itself discarded).
- Simultaneous events: pop and redirect same cycle — pop completes, then flush. Response and pop same cycle on a full queue — both occur. Redirect has priority over every other fetch_pc/queue update.
- halt does not flush; buffered and in-flight words still drain to decode. Deasserting halt resumes at fetch_pc.
- Reset mid-operation: all state cleared; responses to pre-reset requests are not tracked (memory is reset on the same rst).

## Timing
- Reset values: mem_req_valid 0, mem_req_addr RESET_PC, inst_valid 0, inst_data 0, inst_pc 0; fetch_pc RESET_PC, queue empty, drop counter 0.
- First request: cycle after rst falls.
- Request accepted at T, response at T+L (L≥1): inst_valid at T+L+1.
- Sustained 1 instruction/cycle when DEPTH ≥ L+1 and inst_ready held high.
- Redirect at T: first request to new PC at T+1; no pre-redirect word ever appears on inst_* after T.
- No combinational path from any input to inst_*; mem_req_valid depends combinationally only on halt and internal state.

## Structure
- Shared defines file gains INSTR_BYTES (4) and the reset-vector constant; RESET_PC defaults from it.
- One sub-module natural: fetch_queue (slot storage, three pointers, full/empty, flush), parametrised by XLEN and DEPTH.

## Test plan
- Reset, ready=1, L=1, inst_ready=1: requests 0x0,0x4,0x8…; inst_pc 0x0 at cycle 3, then one per cycle, inst_data matching memory.
- inst_ready=0 with DEPTH=4: exactly 4 requests accepted, then mem_req_valid 0; raising inst_ready delivers PCs 0x0–0xC in order, fetching resumes.
- L=3, two in flight, redirect to 0x40: both stale responses discarded, next inst_pc 0x40, next request addr 0x40.
- Redirect to 0x103 in the same cycle as a pop and a response: popped instruction consumed once, response dropped, next request addr 0x100.
- halt raised after 2 requests: mem_req_valid 0, both words still delivered; halt low: next request addr 0x8.
- rst asserted with full queue and 2 in flight: cycle after, inst_valid 0, mem_req_addr RESET_PC.
